// File: rtl/mem_stream_loader.sv
// Byte-stream to 32-bit memory loader: packs incoming bytes little-endian into words
// and writes them to consecutive word addresses starting at a programmed address.
module mem_stream_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DEPTH       = 8192,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    input  logic                   abort,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_WIDTH-1:0] bytes_left,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [3:0]             mem_byteenable,
    output logic                   mem_chipselect,
    output logic                   mem_write,
    output logic [31:0]            mem_writedata,
    output logic                   mem_clken
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  ptr_r, ptr_s;
    logic [1:0]             lane_r, lane_s;
    logic [3:0]             be_r, be_s;
    logic [31:0]            data_r, data_s;
    logic [COUNT_WIDTH-1:0] left_r, left_s;
    logic                   done_r, done_s;
    logic                   aborted_r, aborted_s;

    // Next-state and datapath update; abort overrides every other transition.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        lane_s    = lane_r;
        be_s      = be_r;
        data_s    = data_r;
        left_s    = left_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (byte_count != {COUNT_WIDTH{1'b0}}) begin
                        state_s = COLLECT;
                        ptr_s   = start_addr;
                        left_s  = byte_count;
                        lane_s  = 2'd0;
                        be_s    = 4'b0000;
                        data_s  = 32'h0000_0000;
                    end else begin
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_s   = IDLE;
                    aborted_s = 1'b1;
                    left_s    = {COUNT_WIDTH{1'b0}};
                    lane_s    = 2'd0;
                    be_s      = 4'b0000;
                    data_s    = 32'h0000_0000;
                end else if (in_valid) begin
                    data_s[{lane_r, 3'b000} +: 8] = in_data;
                    be_s[lane_r] = 1'b1;
                    left_s       = left_r - COUNT_WIDTH'(1);
                    lane_s       = lane_r + 2'd1;
                    if ((lane_r == 2'd3) || (left_r == COUNT_WIDTH'(1))) begin
                        state_s = WRITE;
                    end else begin
                        state_s = COLLECT;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            WRITE: begin
                // The strobe of this cycle still completes even if abort is seen now.
                if (abort) begin
                    state_s   = IDLE;
                    aborted_s = 1'b1;
                    left_s    = {COUNT_WIDTH{1'b0}};
                end else begin
                    if (left_r == {COUNT_WIDTH{1'b0}}) begin
                        state_s = FINISH;
                        done_s  = 1'b1;
                    end else begin
                        state_s = COLLECT;
                    end
                end
                ptr_s  = (ptr_r == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : ptr_r + ADDR_WIDTH'(1);
                lane_s = 2'd0;
                be_s   = 4'b0000;
                data_s = 32'h0000_0000;
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= {ADDR_WIDTH{1'b0}};
            lane_r    <= 2'd0;
            be_r      <= 4'b0000;
            data_r    <= 32'h0000_0000;
            left_r    <= {COUNT_WIDTH{1'b0}};
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            lane_r    <= lane_s;
            be_r      <= be_s;
            data_r    <= data_s;
            left_r    <= left_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    // Outputs decode registered state only; the memory bus is zero outside WRITE.
    always_comb begin
        in_ready       = (state_r == COLLECT);
        busy           = (state_r == COLLECT) || (state_r == WRITE);
        done           = done_r;
        aborted        = aborted_r;
        bytes_left     = left_r;
        mem_chipselect = (state_r == WRITE);
        mem_write      = (state_r == WRITE);
        if (state_r == WRITE) begin
            mem_address    = ptr_r;
            mem_byteenable = be_r;
            mem_writedata  = data_r;
        end else begin
            mem_address    = {ADDR_WIDTH{1'b0}};
            mem_byteenable = 4'b0000;
            mem_writedata  = 32'h0000_0000;
        end
        mem_clken      = 1'b1;
    end

endmodule
